// File: rtl/sha1_msg_sequencer_if.sv
// sha1_msg_sequencer_if: big-endian 32-bit message word stream with valid/ready handshake.
// Rev 1.0
`default_nettype none

interface sha1_msg_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;

  modport master (output in_valid, in_data, in_last, in_nbytes, input in_ready);
  modport slave  (input in_valid, in_data, in_last, in_nbytes, output in_ready);
endinterface

`default_nettype wire

// File: rtl/sha1_msg_sequencer.sv
// sha1_msg_sequencer: pads a word-stream message to SHA-1 blocks and feeds sha1core.
// Rev 1.0
`default_nettype none

module sha1_msg_sequencer #(
  parameter int LEN_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  sha1_msg_sequencer_if.slave      in_if,
  output logic                     core_init_o,
  output logic                     core_wr_o,
  output logic [31:0]              core_data_o,
  input  logic                     core_busy_i,
  input  logic [159:0]             h_in_i,
  output logic [159:0]             digest_o,
  output logic                     digest_valid_o,
  output logic                     busy_o
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_DATA    = 4'd2;
  localparam logic [3:0] S_PAD80   = 4'd3;
  localparam logic [3:0] S_ZERO    = 4'd4;
  localparam logic [3:0] S_LENHI   = 4'd5;
  localparam logic [3:0] S_LENLO   = 4'd6;
  localparam logic [3:0] S_BLKWAIT = 4'd7;
  localparam logic [3:0] S_FINWAIT = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [3:0]       ret_q, ret_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic [1:0]       wait_q, wait_d;
  logic             wr_q, wr_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] bitlen;
  logic [63:0]      bitlen64;
  logic             gen;
  logic [31:0]      gen_data;
  logic [3:0]       nxt;

  always_comb begin
    bitlen   = bytes_q << 3;
    bitlen64 = '0;
    bitlen64[LEN_W-1:0] = bitlen;
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    widx_d   = widx_q;
    bytes_d  = bytes_q;
    wait_d   = wait_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    gen      = 1'b0;
    gen_data = '0;
    nxt      = state_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = S_INIT;
      end
      S_INIT: begin
        widx_d  = '0;
        bytes_d = '0;
        wait_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (in_if.in_valid) begin
          if (!in_if.in_last) begin
            gen      = 1'b1;
            gen_data = in_if.in_data;
            bytes_d  = bytes_q + LEN_W'(4);
            nxt      = S_DATA;
          end else begin
            // Partial last word carries the 0x80 marker right after its valid bytes.
            case (in_if.in_nbytes)
              3'd0: state_d = S_PAD80;
              3'd1: begin
                gen      = 1'b1;
                gen_data = {in_if.in_data[31:24], 8'h80, 16'h0000};
                bytes_d  = bytes_q + LEN_W'(1);
                nxt      = S_ZERO;
              end
              3'd2: begin
                gen      = 1'b1;
                gen_data = {in_if.in_data[31:16], 8'h80, 8'h00};
                bytes_d  = bytes_q + LEN_W'(2);
                nxt      = S_ZERO;
              end
              3'd3: begin
                gen      = 1'b1;
                gen_data = {in_if.in_data[31:8], 8'h80};
                bytes_d  = bytes_q + LEN_W'(3);
                nxt      = S_ZERO;
              end
              default: begin
                gen      = 1'b1;
                gen_data = in_if.in_data;
                bytes_d  = bytes_q + LEN_W'(4);
                nxt      = S_PAD80;
              end
            endcase
          end
        end
      end
      S_PAD80: begin
        gen      = 1'b1;
        gen_data = 32'h8000_0000;
        nxt      = S_ZERO;
      end
      S_ZERO: begin
        gen      = 1'b1;
        gen_data = '0;
        nxt      = S_ZERO;
      end
      S_LENHI: begin
        gen      = 1'b1;
        gen_data = bitlen64[63:32];
        nxt      = S_LENLO;
      end
      S_LENLO: begin
        gen      = 1'b1;
        gen_data = bitlen64[31:0];
        nxt      = S_FINWAIT;
      end
      S_BLKWAIT, S_FINWAIT: begin
        // Give the core two cycles to raise busy before trusting a low level.
        if (wait_q != 2'd2) begin
          wait_d = wait_q + 2'd1;
        end else if (!core_busy_i) begin
          wait_d  = '0;
          state_d = (state_q == S_BLKWAIT) ? ret_q : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (gen) begin
      wr_d   = 1'b1;
      data_d = gen_data;
      if (nxt == S_ZERO && widx_q == 4'd13) nxt = S_LENHI;
      if (widx_q == 4'd15) begin
        widx_d  = '0;
        wait_d  = '0;
        ret_d   = nxt;
        state_d = (nxt == S_FINWAIT) ? S_FINWAIT : S_BLKWAIT;
      end else begin
        widx_d  = widx_q + 4'd1;
        state_d = nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      widx_q  <= '0;
      bytes_q <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      widx_q  <= widx_d;
      bytes_q <= bytes_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign in_if.in_ready = (state_q == S_DATA);
  assign core_init_o    = rst | (state_q == S_INIT);
  assign core_wr_o      = wr_q;
  assign core_data_o    = data_q;
  assign digest_o       = h_in_i;
  assign digest_valid_o = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sha1_msg_sequencer.sv
// tb_sha1_msg_sequencer: random and known-vector messages against a padding model and a SHA-1 core model.
// Rev 1.0
`default_nettype none

module tb_sha1_msg_sequencer;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         core_busy;
  logic [159:0] h_q;
  logic         core_init, core_wr, digest_valid, busy;
  logic [31:0]  core_data;
  logic [159:0] digest;

  sha1_msg_sequencer_if sif();

  sha1_msg_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .in_if          (sif),
    .core_init_o    (core_init),
    .core_wr_o      (core_wr),
    .core_data_o    (core_data),
    .core_busy_i    (core_busy),
    .h_in_i         (h_q),
    .digest_o       (digest),
    .digest_valid_o (digest_valid),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  byte unsigned msg_q[$];
  logic [31:0]  got_q[$];
  logic [31:0]  exp_q[$];
  logic [159:0] exp_dig;
  int checks = 0;
  int errors = 0;
  int wr_busy_err = 0;
  bit init_seen = 1'b0;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] sha1_blk(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = rol(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rol(b, 30); b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Core model: collects 16 words, compresses, then stays busy for a random stretch.
  logic [511:0] acc;
  int cnt = 0;
  int busy_left = 0;
  always @(posedge clk) begin
    if (core_init) begin
      h_q       <= IV;
      core_busy <= 1'b0;
      cnt       = 0;
      busy_left = 0;
      init_seen = 1'b1;
    end else begin
      if (busy_left > 0) busy_left--;
      if (core_wr) begin
        if (core_busy) wr_busy_err++;
        got_q.push_back(core_data);
        acc[511-32*cnt -: 32] = core_data;
        cnt++;
        if (cnt == 16) begin
          h_q       <= sha1_blk(h_q, acc);
          cnt       = 0;
          busy_left = $urandom_range(1, 6);
        end
      end
      core_busy <= (busy_left > 0);
    end
  end

  function automatic void build_expected();
    byte unsigned      p[$];
    longint unsigned   bl;
    logic [511:0]      blk;
    logic [159:0]      h;
    p  = msg_q;
    bl = longint'(msg_q.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
    exp_q.delete();
    for (int i = 0; i < p.size() / 4; i++) exp_q.push_back({p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
    h = IV;
    for (int k = 0; k < exp_q.size() / 16; k++) begin
      for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = exp_q[16*k+j];
      h = sha1_blk(h, blk);
    end
    exp_dig = h;
  endfunction

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic set_std_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(8'h61 + i / 4 + i % 4));
  endtask

  task automatic set_rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic pulse_start();
    init_seen   = 1'b0;
    wr_busy_err = 0;
    got_q.delete();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic drive_msg(input int gap_pct, input bit rnd, input bit mid_start, input int max_words);
    int len, nw, total, nb, cyc;
    bit zw, accd;
    logic [31:0] d;
    len   = msg_q.size();
    nw    = (len + 3) / 4;
    zw    = (len == 0) || (rnd && (len % 4 == 0) && ($urandom_range(0, 1) == 1));
    total = zw ? nw + 1 : nw;
    for (int i = 0; i < total && i < max_words; i++) begin
      d = rnd ? $urandom : 32'h0;
      for (int j = 0; j < 4; j++) if (4 * i + j < len) d[31-8*j -: 8] = msg_q[4*i+j];
      nb = (i == total - 1) ? (zw ? 0 : len - 4 * i) : 0;
      accd = 1'b0;
      cyc  = 0;
      while (!accd && cyc < 1000) begin
        @(negedge clk);
        sif.in_valid  = ($urandom_range(0, 99) >= gap_pct);
        sif.in_data   = d;
        sif.in_last   = (i == total - 1);
        sif.in_nbytes = 3'(nb);
        start_i       = mid_start && (i == 1) && (cyc == 0);
        accd          = sif.in_valid && sif.in_ready;
        cyc++;
      end
      if (!accd) begin
        checks++; errors++;
        $display("FAIL in_handshake word %0d: accepted=0 required=1", i);
        break;
      end
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    start_i      = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!digest_valid && cyc < 3000) begin @(negedge clk); cyc++; end
    if (!digest_valid) begin
      checks++; errors++;
      $display("FAIL done_timeout: digest_valid=%0b required=1", digest_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (sif.in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %0b required 0", sif.in_ready); end
    if (core_wr !== 1'b0)        begin errors++; $display("FAIL rst_core_wr: got %0b required 0", core_wr); end
    if (core_data !== 32'h0)     begin errors++; $display("FAIL rst_core_data: got %h required 0", core_data); end
    if (digest_valid !== 1'b0)   begin errors++; $display("FAIL rst_digest_valid: got %0b required 0", digest_valid); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    if (core_init !== 1'b1)      begin errors++; $display("FAIL rst_core_init: got %0b required 1", core_init); end
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (core_init !== 1'b0)      begin errors++; $display("FAIL idle_core_init: got %0b required 0", core_init); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL idle_busy: got %0b required 0", busy); end
  endtask

  task automatic test_abc(input int gap_pct, input string tag);
    int fd;
    set_std_msg(0);
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    build_expected();
    pulse_start();
    drive_msg(gap_pct, 1'b0, 1'b0, 99);
    wait_done();
    fd = first_diff();
    checks += 6;
    if (fd !== -1) begin errors++; $display("FAIL %s_words: first diff %0d, got %0d words required %0d", tag, fd, got_q.size(), exp_q.size()); end
    if (got_q[0] !== 32'h61626380) begin errors++; $display("FAIL %s_word0: got %h required 61626380", tag, got_q[0]); end
    if (got_q[15] !== 32'h00000018) begin errors++; $display("FAIL %s_word15: got %h required 00000018", tag, got_q[15]); end
    if (digest !== 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D) begin errors++; $display("FAIL %s_digest: got %h required a9993e36...", tag, digest); end
    if (wr_busy_err !== 0) begin errors++; $display("FAIL %s_wr_while_busy: got %0d required 0", tag, wr_busy_err); end
    if (init_seen !== 1'b1) begin errors++; $display("FAIL %s_core_init: got %0b required 1", tag, init_seen); end
  endtask

  task automatic test_empty();
    int fd;
    msg_q.delete();
    build_expected();
    pulse_start();
    drive_msg(0, 1'b1, 1'b0, 99);
    wait_done();
    fd = first_diff();
    checks += 3;
    if (fd !== -1) begin errors++; $display("FAIL empty_words: first diff %0d, got %0d words required %0d", fd, got_q.size(), exp_q.size()); end
    if (got_q[0] !== 32'h80000000) begin errors++; $display("FAIL empty_word0: got %h required 80000000", got_q[0]); end
    if (digest !== 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709) begin errors++; $display("FAIL empty_digest: got %h required da39a3ee...", digest); end
  endtask

  task automatic test_two_block();
    int fd;
    set_std_msg(56);
    build_expected();
    pulse_start();
    drive_msg(0, 1'b0, 1'b0, 99);
    wait_done();
    fd = first_diff();
    checks += 5;
    if (fd !== -1) begin errors++; $display("FAIL blk2_words: first diff %0d, got %0d words required %0d", fd, got_q.size(), exp_q.size()); end
    if (got_q[14] !== 32'h80000000) begin errors++; $display("FAIL blk2_word14: got %h required 80000000", got_q[14]); end
    if (got_q[31] !== 32'h000001C0) begin errors++; $display("FAIL blk2_word31: got %h required 000001c0", got_q[31]); end
    if (digest !== 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1) begin errors++; $display("FAIL blk2_digest: got %h required 84983e44...", digest); end
    if (wr_busy_err !== 0) begin errors++; $display("FAIL blk2_wr_while_busy: got %0d required 0", wr_busy_err); end
  endtask

  task automatic test_55_boundary();
    int fd;
    set_std_msg(55);
    build_expected();
    pulse_start();
    drive_msg(0, 1'b0, 1'b0, 99);
    wait_done();
    fd = first_diff();
    checks += 5;
    if (fd !== -1) begin errors++; $display("FAIL b55_words: first diff %0d, got %0d words required %0d", fd, got_q.size(), exp_q.size()); end
    if (got_q.size() !== 16) begin errors++; $display("FAIL b55_count: got %0d required 16", got_q.size()); end
    if (got_q[13] !== 32'h6E6F7080) begin errors++; $display("FAIL b55_word13: got %h required 6e6f7080", got_q[13]); end
    if (got_q[15] !== 32'h000001B8) begin errors++; $display("FAIL b55_word15: got %h required 000001b8", got_q[15]); end
    if (digest !== exp_dig) begin errors++; $display("FAIL b55_digest: got %h required %h", digest, exp_dig); end
  endtask

  task automatic test_rst_abort();
    set_rand_msg(40);
    pulse_start();
    drive_msg(0, 1'b1, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    checks += 5;
    if (core_init !== 1'b1)    begin errors++; $display("FAIL abort_core_init: got %0b required 1", core_init); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL abort_busy: got %0b required 0", busy); end
    if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %0b required 0", sif.in_ready); end
    if (digest_valid !== 1'b0) begin errors++; $display("FAIL abort_digest_valid: got %0b required 0", digest_valid); end
    if (core_wr !== 1'b0)      begin errors++; $display("FAIL abort_core_wr: got %0b required 0", core_wr); end
    rst = 1'b0;
    @(negedge clk);
    test_abc(0, "post_abort");
  endtask

  task automatic test_back_to_back(input int n, input bit mid_start);
    int fd;
    set_rand_msg(n);
    build_expected();
    pulse_start();
    checks += 2;
    if (digest_valid !== 1'b0) begin errors++; $display("FAIL b2b_digest_valid_drop: got %0b required 0", digest_valid); end
    if (busy !== 1'b1)         begin errors++; $display("FAIL b2b_busy: got %0b required 1", busy); end
    drive_msg(30, 1'b1, mid_start, 99);
    wait_done();
    fd = first_diff();
    checks += 3;
    if (fd !== -1) begin errors++; $display("FAIL b2b_words len %0d: first diff %0d, got %0d words required %0d", n, fd, got_q.size(), exp_q.size()); end
    if (digest !== exp_dig) begin errors++; $display("FAIL b2b_digest len %0d: got %h required %h", n, digest, exp_dig); end
    if (wr_busy_err !== 0) begin errors++; $display("FAIL b2b_wr_while_busy: got %0d required 0", wr_busy_err); end
  endtask

  task automatic test_random(input int iters);
    int fd, n;
    for (int it = 0; it < iters; it++) begin
      n = $urandom_range(0, 140);
      set_rand_msg(n);
      build_expected();
      pulse_start();
      drive_msg($urandom_range(0, 60), 1'b1, (n > 8) && ($urandom_range(0, 1) == 1), 99);
      wait_done();
      fd = first_diff();
      checks += 4;
      if (fd !== -1) begin errors++; $display("FAIL rand_words len %0d: first diff %0d, got %0d words required %0d", n, fd, got_q.size(), exp_q.size()); end
      if (digest !== exp_dig) begin errors++; $display("FAIL rand_digest len %0d: got %h required %h", n, digest, exp_dig); end
      if (wr_busy_err !== 0) begin errors++; $display("FAIL rand_wr_while_busy len %0d: got %0d required 0", n, wr_busy_err); end
      if (init_seen !== 1'b1) begin errors++; $display("FAIL rand_core_init len %0d: got %0b required 1", n, init_seen); end
    end
  endtask

  initial begin
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.in_last   = 1'b0;
    sif.in_nbytes = '0;
    test_reset();
    test_abc(0, "abc");
    test_empty();
    test_two_block();
    test_55_boundary();
    for (int i = 0; i < 3; i++) test_abc(50, "abc_gaps");
    test_rst_abort();
    test_back_to_back(61, 1'b1);
    test_back_to_back(64, 1'b0);
    test_random(12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
